// File: rtl/ann_pkg.sv
// Shared geometry defaults, FSM state encoding and helpers for the best-array sender.
package ann_pkg;
  localparam int unsigned DATA_WIDTH = 11;
  localparam int unsigned ROW_SIZE   = 26;
  localparam int unsigned COL_SIZE   = 19;
  localparam int unsigned BLOCKING   = 4;
  localparam int unsigned NUM_QUERYS = ROW_SIZE * COL_SIZE;
  localparam int unsigned ADDR_W     = 9;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    FINISH
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/best_arr_sender_if.sv
// Result-memory read port and output-FIFO write port of the best-array sender.
interface best_arr_sender_if
  import ann_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ann_pkg::DATA_WIDTH
);
  logic                      mem_ren;
  logic [ADDR_W-1:0]         mem_raddr;
  logic [DATA_WIDTH-1:0]     mem_ridx;
  logic [2*DATA_WIDTH-1:0]   mem_rdist;
  logic                      out_fifo_wenq;
  logic [DATA_WIDTH-1:0]     out_fifo_wdata;
  logic                      out_fifo_wfull_n;

  modport master (
    output mem_ren, mem_raddr, out_fifo_wenq, out_fifo_wdata,
    input  mem_ridx, mem_rdist, out_fifo_wfull_n
  );

  modport slave (
    input  mem_ren, mem_raddr, out_fifo_wenq, out_fifo_wdata,
    output mem_ridx, mem_rdist, out_fifo_wfull_n
  );
endinterface

// File: rtl/blk_addr_gen.sv
// Nested phase/px/x/y/xi traversal counters and the blocked query address they select.
module blk_addr_gen
  import ann_pkg::*;
#(
  parameter int unsigned ROW_SIZE = ann_pkg::ROW_SIZE,
  parameter int unsigned COL_SIZE = ann_pkg::COL_SIZE,
  parameter int unsigned BLOCKING = ann_pkg::BLOCKING
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  output logic              o_phase
);
  localparam int unsigned HALF = ROW_SIZE / 2;
  localparam int unsigned XN   = ceil_div(HALF, BLOCKING);
  localparam int unsigned XW   = (XN > 1) ? $clog2(XN) : 1;
  localparam int unsigned YW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int unsigned IW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

  logic          r_phase;
  logic          r_px;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [IW-1:0] r_xi;

  logic [31:0]   w_col;
  logic          w_xi_end;
  logic          w_y_end;
  logic          w_x_end;

  assign w_col    = 32'(r_x) * BLOCKING + 32'(r_xi);
  // xi wraps early past the half-row edge, so padded columns of the last block are never visited
  assign w_xi_end = (32'(r_xi) == BLOCKING - 1) || (w_col + 1 >= HALF);
  assign w_y_end  = (32'(r_y) == COL_SIZE - 1);
  assign w_x_end  = (32'(r_x) == XN - 1);

  assign o_valid  = (w_col < HALF);
  assign o_addr   = ADDR_W'(32'(r_px) * HALF + 32'(r_y) * ROW_SIZE + w_col);
  assign o_last   = r_phase & r_px & w_x_end & w_y_end & w_xi_end;
  assign o_phase  = r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_px    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_xi    <= '0;
    end else if (i_inc) begin
      if (!w_xi_end) begin
        r_xi <= r_xi + 1'b1;
      end else begin
        r_xi <= '0;
        if (!w_y_end) begin
          r_y <= r_y + 1'b1;
        end else begin
          r_y <= '0;
          if (!w_x_end) begin
            r_x <= r_x + 1'b1;
          end else begin
            r_x <= '0;
            if (!r_px) begin
              r_px <= 1'b1;
            end else begin
              r_px    <= 1'b0;
              r_phase <= ~r_phase;
            end
          end
        end
      end
    end
  end
endmodule

// File: rtl/best_arr_sender.sv
// Streams best indices, then best distances (two words each), from the result memory into the output FIFO.
module best_arr_sender
  import ann_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ann_pkg::DATA_WIDTH,
  parameter int unsigned ROW_SIZE   = ann_pkg::ROW_SIZE,
  parameter int unsigned COL_SIZE   = ann_pkg::COL_SIZE,
  parameter int unsigned BLOCKING   = ann_pkg::BLOCKING
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_best_arr,
  output logic              busy,
  output logic              done,
  best_arr_sender_if.master bus
);
  state_t                  r_state;
  state_t                  w_next;
  logic                    r_half;
  logic [DATA_WIDTH-1:0]   r_idx;
  logic [2*DATA_WIDTH-1:0] r_dist;

  logic                    w_valid;
  logic                    w_last;
  logic                    w_phase;
  logic [ADDR_W-1:0]       w_addr;
  logic                    w_accept;
  logic                    w_entry_done;
  logic                    w_inc;

  assign w_accept     = (r_state == SEND) && bus.out_fifo_wfull_n;
  assign w_entry_done = w_accept && (!w_phase || r_half);
  assign w_inc        = ((r_state == READ) && !w_valid) || w_entry_done;

  blk_addr_gen #(
    .ROW_SIZE (ROW_SIZE),
    .COL_SIZE (COL_SIZE),
    .BLOCKING (BLOCKING)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .o_valid (w_valid),
    .o_addr  (w_addr),
    .o_last  (w_last),
    .o_phase (w_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_half  <= '0;
      r_idx   <= '0;
      r_dist  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CAPTURE) begin
        r_idx  <= bus.mem_ridx;
        r_dist <= bus.mem_rdist;
      end
      if (w_accept && w_phase) begin
        r_half <= ~r_half;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (send_best_arr) w_next = READ;
      READ:    if (w_valid) w_next = CAPTURE;
      CAPTURE: w_next = SEND;
      SEND:    if (w_entry_done) w_next = w_last ? FINISH : READ;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_ren        = 1'b0;
    bus.mem_raddr      = '0;
    bus.out_fifo_wenq  = 1'b0;
    bus.out_fifo_wdata = '0;
    busy               = (r_state != IDLE);
    done               = (r_state == FINISH);
    case (r_state)
      READ: begin
        if (w_valid) begin
          bus.mem_ren   = 1'b1;
          bus.mem_raddr = w_addr;
        end
      end
      SEND: begin
        if (bus.out_fifo_wfull_n) begin
          bus.out_fifo_wenq = 1'b1;
          if (!w_phase)
            bus.out_fifo_wdata = r_idx;
          else if (r_half)
            bus.out_fifo_wdata = r_dist[2*DATA_WIDTH-1:DATA_WIDTH];
          else
            bus.out_fifo_wdata = r_dist[DATA_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_best_arr_sender.sv
// Self-checking bench: table of transfer scenarios checked against a loop-level reference model.
module tb_best_arr_sender;
  localparam int unsigned DW   = 11;
  localparam int unsigned ROW  = 26;
  localparam int unsigned COL  = 19;
  localparam int unsigned BLK  = 4;
  localparam int unsigned HALF = ROW / 2;
  localparam int unsigned XN   = (HALF + BLK - 1) / BLK;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic send = 1'b0;
  logic busy;
  logic done;

  best_arr_sender_if #(.DATA_WIDTH(DW)) bus ();

  best_arr_sender #(
    .DATA_WIDTH (DW),
    .ROW_SIZE   (ROW),
    .COL_SIZE   (COL),
    .BLOCKING   (BLK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .send_best_arr (send),
    .busy          (busy),
    .done          (done),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]   idx_mem  [0:511];
  logic [2*DW-1:0] dist_mem [0:511];

  always @(posedge clk) begin
    if (bus.mem_ren) begin
      bus.mem_ridx  <= idx_mem[bus.mem_raddr];
      bus.mem_rdist <= dist_mem[bus.mem_raddr];
    end
  end

  bit bp_on = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.out_fifo_wfull_n = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [DW-1:0] got[$];
  int            reads[$];
  int            done_cnt, viol_full, viol_zero, viol_busy;

  always @(negedge clk) begin
    if (bus.out_fifo_wenq) begin
      got.push_back(bus.out_fifo_wdata);
      if (!bus.out_fifo_wfull_n) viol_full++;
    end else if (bus.out_fifo_wdata != '0) begin
      viol_zero++;
    end
    if (bus.mem_ren) reads.push_back(int'(bus.mem_raddr));
    if (done) begin
      done_cnt++;
      if (!busy) viol_busy++;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  logic [DW-1:0] exp_words[$];
  int            exp_reads[$];

  // Expected stream written directly from the traversal rules as plain nested loops
  task automatic build_model();
    logic [2*DW-1:0] d;
    int a, c;
    exp_words.delete();
    exp_reads.delete();
    for (int ph = 0; ph < 2; ph++)
      for (int px = 0; px < 2; px++)
        for (int x = 0; x < int'(XN); x++)
          for (int y = 0; y < int'(COL); y++)
            for (int xi = 0; xi < int'(BLK); xi++) begin
              c = x * int'(BLK) + xi;
              if (c >= int'(HALF)) continue;
              a = px * int'(HALF) + y * int'(ROW) + c;
              exp_reads.push_back(a);
              if (ph == 0) begin
                exp_words.push_back(idx_mem[a]);
              end else begin
                d = dist_mem[a];
                exp_words.push_back(d[DW-1:0]);
                exp_words.push_back(d[2*DW-1:DW]);
              end
            end
  endtask

  task automatic load_mem(input int kind);
    for (int a = 0; a < 512; a++) begin
      if (kind == 1) begin
        idx_mem[a]  = 11'($urandom);
        dist_mem[a] = 22'($urandom);
      end else begin
        idx_mem[a]  = 11'(a);
        dist_mem[a] = 22'(a * 4099);
      end
    end
    if (kind == 2) dist_mem[0] = 22'h3FFFFF;
  endtask

  task automatic clear_mon();
    got.delete();
    reads.delete();
    done_cnt  = 0;
    viol_full = 0;
    viol_zero = 0;
    viol_busy = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    send = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  longint'(busy), 0);
    chk("rst_done",  longint'(done), 0);
    chk("rst_ren",   longint'(bus.mem_ren), 0);
    chk("rst_raddr", longint'(bus.mem_raddr), 0);
    chk("rst_wenq",  longint'(bus.out_fifo_wenq), 0);
    chk("rst_wdata", longint'(bus.out_fifo_wdata), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_xfer();
    @(negedge clk);
    chk("idle_busy", longint'(busy), 0);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("start_busy",  longint'(busy), 1);
    chk("start_ren",   longint'(bus.mem_ren), 1);
    chk("start_raddr", longint'(bus.mem_raddr), 0);
    @(negedge clk);
    chk("capture_ren", longint'(bus.mem_ren), 0);
  endtask

  task automatic wait_done(input bit spam, output bit ok);
    ok = 1'b0;
    for (int c = 1; c < 20000; c++) begin
      @(negedge clk);
      send = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (spam && (c % 37 == 0)) send = 1'b1;
    end
    send = 1'b0;
  endtask

  typedef struct {
    string name;
    int    mem_kind;
    bit    bp;
    bit    spam;
    int    abort_at;
    int    exp_words;
    int    exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int bad;

    vecs[0] = '{"linear",      0, 1'b0, 1'b0, 0,   1482, 1};
    vecs[1] = '{"linear_bp",   0, 1'b1, 1'b0, 0,   1482, 1};
    vecs[2] = '{"random_bp",   1, 1'b1, 1'b0, 0,   1482, 1};
    vecs[3] = '{"dist_max",    2, 1'b0, 1'b0, 0,   1482, 1};
    vecs[4] = '{"start_spam",  0, 1'b1, 1'b1, 0,   1482, 1};
    vecs[5] = '{"abort_reset", 1, 1'b1, 1'b0, 100, 1482, 1};

    for (int v = 0; v < 6; v++) begin
      load_mem(vecs[v].mem_kind);
      build_model();
      bp_on = vecs[v].bp;
      do_reset();
      clear_mon();
      start_xfer();

      if (vecs[v].abort_at > 0) begin
        for (int c = 0; c < 5000 && got.size() < vecs[v].abort_at; c++) @(negedge clk);
        chk({vecs[v].name, "_reached"}, longint'(got.size() >= vecs[v].abort_at), 1);
        do_reset();
        chk({vecs[v].name, "_no_done"}, longint'(done_cnt), 0);
        clear_mon();
        start_xfer();
      end

      wait_done(vecs[v].spam, ok);
      chk({vecs[v].name, "_done_seen"}, longint'(ok), 1);
      repeat (30) @(negedge clk);

      chk({vecs[v].name, "_count"},     longint'(got.size()), longint'(vecs[v].exp_words));
      chk({vecs[v].name, "_model_cnt"}, longint'(got.size()), longint'(exp_words.size()));
      chk({vecs[v].name, "_done_cnt"},  longint'(done_cnt), longint'(vecs[v].exp_done));
      chk({vecs[v].name, "_full_enq"},  longint'(viol_full), 0);
      chk({vecs[v].name, "_idle_data"}, longint'(viol_zero), 0);
      chk({vecs[v].name, "_busy_fin"},  longint'(viol_busy), 0);
      chk({vecs[v].name, "_end_busy"},  longint'(busy), 0);

      tests++;
      bad = -1;
      for (int i = 0; i < exp_words.size() && i < got.size(); i++)
        if (got[i] !== exp_words[i]) begin
          bad = i;
          break;
        end
      if (bad >= 0) begin
        fails++;
        $display("FAIL %s_words: word %0d got %0h, expected %0h",
                 vecs[v].name, bad, got[bad], exp_words[bad]);
      end

      tests++;
      bad = -1;
      if (reads.size() != exp_reads.size()) bad = reads.size();
      for (int i = 0; i < exp_reads.size() && i < reads.size(); i++)
        if (reads[i] != exp_reads[i]) begin
          bad = i;
          break;
        end
      if (bad >= 0) begin
        fails++;
        $display("FAIL %s_reads: read %0d of %0d got addr %0d, expected %0d",
                 vecs[v].name, bad, reads.size(),
                 (bad < reads.size()) ? reads[bad] : -1,
                 (bad < exp_reads.size()) ? exp_reads[bad] : -1);
      end

      if (vecs[v].mem_kind == 2) begin
        if (got.size() > 495) begin
          chk("dist_max_lo", longint'(got[494]), 64'h7FF);
          chk("dist_max_hi", longint'(got[495]), 64'h7FF);
        end else begin
          chk("dist_max_len", longint'(got.size()), 1482);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
